// File: rtl/huc_mem_resp.sv
// Mapper-side request to async SRAM/PSRAM cycle sequencer.
// Optional single-entry read cache: define HUC_MEM_RD_CACHE_EN.
module huc_mem_resp #(
  parameter int ADDR_W   = 19,
  parameter int WAIT_CYC = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_dati,
  output logic [7:0]        mem_dato,
  input  logic              mem_ce,
  input  logic              mem_ce2,
  input  logic              mem_oe,
  input  logic              mem_we,
  output logic              busy,
  output logic [ADDR_W-1:0] ext_addr,
  output logic [7:0]        ext_dq_o,
  input  logic [7:0]        ext_dq_i,
  output logic              ext_dq_oe,
  output logic              ext_ce_n,
  output logic              ext_oe_n,
  output logic              ext_we_n
);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    STROBE,
    HOLD,
    WAIT_REL
  } state_t;

  state_t            state_q, state_d;
  logic              req_q, req_d;
  logic              armed_q, armed_d;
  logic              wr_q, wr_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        dq_o_q, dq_o_d;
  logic [7:0]        dato_q, dato_d;
  logic              ce_n_q, ce_n_d;
  logic              oe_n_q, oe_n_d;
  logic              we_n_q, we_n_d;
  logic              dq_oe_q, dq_oe_d;
  logic              busy_q, busy_d;
  logic              req, start, hit;

`ifdef HUC_MEM_RD_CACHE_EN
  logic              cv_q, cv_d;
  logic [ADDR_W-1:0] tag_q, tag_d;
  logic [7:0]        cdat_q, cdat_d;
`endif

  always_comb begin
    state_d = state_q;
    wr_d    = wr_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    dq_o_d  = dq_o_q;
    dato_d  = dato_q;
    ce_n_d  = ce_n_q;
    oe_n_d  = oe_n_q;
    we_n_d  = we_n_q;
    dq_oe_d = dq_oe_q;
    busy_d  = busy_q;
`ifdef HUC_MEM_RD_CACHE_EN
    cv_d    = cv_q;
    tag_d   = tag_q;
    cdat_d  = cdat_q;
`endif
    req     = mem_ce & mem_ce2 & (mem_oe | mem_we);
    req_d   = req;
    // A request still high out of reset must fall once before it counts
    armed_d = armed_q | ~req;
    start   = req & ~req_q & armed_q;
`ifdef HUC_MEM_RD_CACHE_EN
    hit     = mem_oe & cv_q & (tag_q == mem_addr);
`else
    hit     = 1'b0;
`endif

    unique case (state_q)
      IDLE: begin
        if (start) begin
          addr_d = mem_addr;
          wr_d   = ~mem_oe;
          if (!mem_oe) dq_o_d = mem_dati;
`ifdef HUC_MEM_RD_CACHE_EN
          if (!mem_oe && cv_q && tag_q == mem_addr)
            cdat_d = mem_dati;
          if (hit) dato_d = cdat_q;
`endif
          if (hit) begin
            state_d = WAIT_REL;
          end else begin
            state_d = SETUP;
            ce_n_d  = 1'b0;
            busy_d  = 1'b1;
            dq_oe_d = ~mem_oe;
          end
        end
      end
      SETUP: begin
        state_d = STROBE;
        cnt_d   = 4'(WAIT_CYC - 1);
        if (wr_q) we_n_d = 1'b0;
        else      oe_n_d = 1'b0;
      end
      STROBE: begin
        if (cnt_q == 4'd0) begin
          state_d = HOLD;
          oe_n_d  = 1'b1;
          we_n_d  = 1'b1;
          if (!wr_q) begin
            dato_d = ext_dq_i;
`ifdef HUC_MEM_RD_CACHE_EN
            cv_d   = 1'b1;
            tag_d  = addr_q;
            cdat_d = ext_dq_i;
`endif
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      HOLD: begin
        ce_n_d  = 1'b1;
        dq_oe_d = 1'b0;
        busy_d  = 1'b0;
        state_d = req ? WAIT_REL : IDLE;
      end
      WAIT_REL: begin
        if (!req) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        ce_n_d  = 1'b1;
        oe_n_d  = 1'b1;
        we_n_d  = 1'b1;
        dq_oe_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      armed_q <= 1'b0;
      wr_q    <= 1'b0;
      cnt_q   <= 4'd0;
      addr_q  <= '0;
      dq_o_q  <= 8'h00;
      dato_q  <= 8'h00;
      ce_n_q  <= 1'b1;
      oe_n_q  <= 1'b1;
      we_n_q  <= 1'b1;
      dq_oe_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      armed_q <= armed_d;
      wr_q    <= wr_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      dq_o_q  <= dq_o_d;
      dato_q  <= dato_d;
      ce_n_q  <= ce_n_d;
      oe_n_q  <= oe_n_d;
      we_n_q  <= we_n_d;
      dq_oe_q <= dq_oe_d;
      busy_q  <= busy_d;
    end
  end

`ifdef HUC_MEM_RD_CACHE_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cv_q   <= 1'b0;
      tag_q  <= '0;
      cdat_q <= 8'h00;
    end else begin
      cv_q   <= cv_d;
      tag_q  <= tag_d;
      cdat_q <= cdat_d;
    end
  end
`endif

  assign mem_dato  = dato_q;
  assign busy      = busy_q;
  assign ext_addr  = addr_q;
  assign ext_dq_o  = dq_o_q;
  assign ext_dq_oe = dq_oe_q;
  assign ext_ce_n  = ce_n_q;
  assign ext_oe_n  = oe_n_q;
  assign ext_we_n  = we_n_q;

endmodule

// File: tb/tb_huc_mem_resp.sv
// Bench for huc_mem_resp: directed table, corner sequences, random traffic.
// Build with HUC_MEM_RD_CACHE_EN to exercise the read cache model.
module tb_huc_mem_resp;
  localparam int W = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [18:0] mem_addr;
  logic [7:0]  mem_dati;
  logic [7:0]  mem_dato;
  logic        mem_ce, mem_ce2, mem_oe, mem_we;
  logic        busy;
  logic [18:0] ext_addr;
  logic [7:0]  ext_dq_o, ext_dq_i;
  logic        ext_dq_oe, ext_ce_n, ext_oe_n, ext_we_n;

  huc_mem_resp #(.ADDR_W(19), .WAIT_CYC(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_addr(mem_addr), .mem_dati(mem_dati),
    .mem_dato(mem_dato), .mem_ce(mem_ce),
    .mem_ce2(mem_ce2), .mem_oe(mem_oe),
    .mem_we(mem_we), .busy(busy),
    .ext_addr(ext_addr), .ext_dq_o(ext_dq_o),
    .ext_dq_i(ext_dq_i), .ext_dq_oe(ext_dq_oe),
    .ext_ce_n(ext_ce_n), .ext_oe_n(ext_oe_n),
    .ext_we_n(ext_we_n)
  );

  always #5 clk = ~clk;

  // Pin-level SRAM: 256 bytes, preset to addr^5A until written
  logic [7:0] sram [256];
  bit         written [256];
  always @(posedge clk) begin
    if (!ext_ce_n && !ext_we_n && ext_dq_oe) begin
      sram[ext_addr[7:0]]    <= ext_dq_o;
      written[ext_addr[7:0]] <= 1'b1;
    end
  end
  assign ext_dq_i = written[ext_addr[7:0]] ?
    sram[ext_addr[7:0]] : (ext_addr[7:0] ^ 8'h5A);

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] ref_mem [256];
`ifdef HUC_MEM_RD_CACHE_EN
  bit          m_cv = 1'b0;
  logic [18:0] m_tag;
`endif

  typedef struct {
    logic [18:0] addr;
    logic [7:0]  dat;
    bit          oe;
    bit          we;
    logic [7:0]  exp;
    int          extra;
    bit          early;
  } vec_t;
  vec_t tbl [10];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h @%0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_access(input logic [18:0] a,
                            input logic [7:0] d,
                            input bit oe, input bit we,
                            input logic [7:0] e,
                            input int extra,
                            input bit early);
    bit hit, wr, strb;
    hit = 1'b0;
    wr  = !oe;
`ifdef HUC_MEM_RD_CACHE_EN
    hit = oe && m_cv && (m_tag == a);
`endif
    mem_addr = a;
    mem_dati = d;
    mem_oe   = oe;
    mem_we   = we;
    mem_ce   = 1'b1;
    mem_ce2  = 1'b1;
    step();
    if (hit) begin
      chk("hit_busy", 32'(busy), 0);
      chk("hit_ce_n", 32'(ext_ce_n), 1);
      chk("hit_data", 32'(mem_dato), 32'(e));
    end else begin
      for (int k = 1; k <= W + 2; k++) begin
        strb = (k >= 2) && (k <= W + 1);
        chk("busy", 32'(busy), 1);
        chk("ce_n", 32'(ext_ce_n), 0);
        chk("oe_n", 32'(ext_oe_n), (!wr && strb) ? 0 : 1);
        chk("we_n", 32'(ext_we_n), (wr && strb) ? 0 : 1);
        chk("dq_oe", 32'(ext_dq_oe), 32'(wr));
        chk("ext_addr", 32'(ext_addr), 32'(a));
        if (wr) chk("dq_o", 32'(ext_dq_o), 32'(d));
        if (!wr && k == W + 2)
          chk("rd_data", 32'(mem_dato), 32'(e));
        mem_addr = 19'($urandom);
        mem_dati = 8'($urandom);
        if (early && k == 1) mem_ce = 1'b0;
        step();
      end
      chk("end_busy", 32'(busy), 0);
      chk("end_ce_n", 32'(ext_ce_n), 1);
    end
    if (!wr) chk("rd_hold", 32'(mem_dato), 32'(e));
    if (wr) ref_mem[a[7:0]] = d;
`ifdef HUC_MEM_RD_CACHE_EN
    if (!wr && !hit) begin
      m_cv  = 1'b1;
      m_tag = a;
    end
`endif
    if (early && !hit) return;
    for (int i = 0; i < extra; i++) begin
      chk("held_ce_n", 32'(ext_ce_n), 1);
      chk("held_busy", 32'(busy), 0);
      step();
    end
    mem_ce = 1'b0;
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0]  lo;
    logic [18:0] ra;
    logic [7:0]  rd;
    int          kind;
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'(i) ^ 8'h5A;

    tbl[0] = '{19'h40010, 8'h3C, 0, 1, 8'h00, 0, 0};
    tbl[1] = '{19'h40010, 8'h00, 1, 0, 8'h3C, 0, 0};
    tbl[2] = '{19'h00123, 8'hA5, 0, 1, 8'h00, 0, 0};
    tbl[3] = '{19'h00123, 8'h00, 1, 0, 8'hA5, 0, 0};
    tbl[4] = '{19'h40010, 8'hFF, 1, 1, 8'h3C, 2, 0};
    tbl[5] = '{19'h00005, 8'h00, 1, 0, 8'h5F, 0, 0};
    tbl[6] = '{19'h00123, 8'h00, 1, 0, 8'hA5, 17, 0};
    tbl[7] = '{19'h00123, 8'h00, 1, 0, 8'hA5, 1, 0};
    tbl[8] = '{19'h00123, 8'h66, 0, 1, 8'h00, 0, 1};
    tbl[9] = '{19'h00123, 8'h00, 1, 0, 8'h66, 0, 0};

    rst_n    = 1'b0;
    mem_addr = '0;
    mem_dati = '0;
    mem_ce   = 1'b0;
    mem_ce2  = 1'b0;
    mem_oe   = 1'b0;
    mem_we   = 1'b0;
    step();
    step();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ce_n", 32'(ext_ce_n), 1);
    chk("rst_oe_n", 32'(ext_oe_n), 1);
    chk("rst_we_n", 32'(ext_we_n), 1);
    chk("rst_dq_oe", 32'(ext_dq_oe), 0);
    chk("rst_dato", 32'(mem_dato), 0);
    chk("rst_addr", 32'(ext_addr), 0);
    chk("rst_dq_o", 32'(ext_dq_o), 0);
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 10; i++)
      run_access(tbl[i].addr, tbl[i].dat, tbl[i].oe,
                 tbl[i].we, tbl[i].exp, tbl[i].extra,
                 tbl[i].early);

    // Reset in the middle of a write strobe
    mem_addr = 19'h00077;
    mem_dati = 8'hE1;
    mem_oe   = 1'b0;
    mem_we   = 1'b1;
    mem_ce   = 1'b1;
    mem_ce2  = 1'b1;
    step();
    step();
    chk("mid_we_n", 32'(ext_we_n), 0);
    rst_n = 1'b0;
    #1;
    chk("arst_we_n", 32'(ext_we_n), 1);
    chk("arst_dq_oe", 32'(ext_dq_oe), 0);
    chk("arst_ce_n", 32'(ext_ce_n), 1);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_dato", 32'(mem_dato), 0);
`ifdef HUC_MEM_RD_CACHE_EN
    m_cv = 1'b0;
`endif
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("post_rst_ce_n", 32'(ext_ce_n), 1);
      chk("post_rst_busy", 32'(busy), 0);
    end
    mem_ce = 1'b0;
    step();
    run_access(19'h40010, 8'h00, 1, 0, ref_mem[8'h10], 0, 0);

    for (int n = 0; n < 40; n++) begin
      lo   = 8'($urandom_range(128, 255));
      ra   = {lo ^ 8'h33, 3'b101, lo};
      rd   = 8'($urandom);
      kind = $urandom_range(0, 2);
      run_access(ra, rd, kind != 1, kind != 0,
                 ref_mem[lo], $urandom_range(0, 3),
                 $urandom_range(0, 3) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/huc_mem_resp.md
HUC_MEM_RESP -- requirements
Module: huc_mem_resp

Interface
REQ-001 SHALL have parameter ADDR_W, default 19, memory-side address width (512K window).
REQ-002 SHALL have parameter WAIT_CYC, default 3, strobe-low cycles per external access (legal range 1..15).
REQ-003 SHALL have port clk  in  1  system clock; all state on its rising edge.
REQ-004 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port mem_addr  in  ADDR_W  request address from the cartridge mapper.
REQ-006 SHALL have port mem_dati  in  8  write data from the mapper.
REQ-007 SHALL have port mem_dato  out  8  read data returned to the mapper.
REQ-008 SHALL have port mem_ce  in  1  chip select for this memory.
REQ-009 SHALL have port mem_ce2  in  1  CPU bus-cycle qualifier.
REQ-010 SHALL have ports mem_oe, mem_we  in  1 each  read and write request.
REQ-011 SHALL have port busy  out  1  high while an external access is in progress.
REQ-012 SHALL have ports ext_addr  out  ADDR_W, ext_dq_o  out  8, ext_dq_i  in  8, ext_dq_oe  out  1, ext_ce_n, ext_oe_n, ext_we_n  out  1 each  async SRAM/PSRAM pins.

Function
REQ-013 SHALL define req = mem_ce & mem_ce2 & (mem_oe | mem_we) and start an access only on a 0->1 transition of req, registered in clk; at most one access per req assertion.
REQ-014 SHALL give mem_oe priority: if mem_oe and mem_we are both high, the access is a read and no write strobe is issued.
REQ-015 SHALL capture mem_addr, mem_dati and the direction into registers on the start cycle; later input changes SHALL NOT affect the running access.
REQ-016 SHALL implement states IDLE, SETUP, STROBE, HOLD, WAIT_REL.
REQ-017 IDLE->SETUP on start; SETUP lasts 1 cycle with ext_ce_n=0, address valid, strobes high.
REQ-018 STROBE SHALL last exactly WAIT_CYC cycles with ext_oe_n=0 (read) or ext_we_n=0 (write), counted by a 4-bit down-counter.
REQ-019 For reads, mem_dato SHALL load ext_dq_i on the last STROBE cycle and hold that value until the next completed read.
REQ-020 HOLD SHALL last 1 cycle: strobes high, ext_ce_n=0, write data still driven.
REQ-021 WAIT_REL SHALL hold until req=0, then return to IDLE; the transition into IDLE SHALL be ready to see a new rising edge on the following cycle.
REQ-022 ext_dq_oe SHALL be high from SETUP through HOLD for writes only, and low otherwise.
REQ-023 busy SHALL be high in SETUP, STROBE and HOLD, low in IDLE and WAIT_REL; read latency from start = WAIT_CYC+2 cycles to mem_dato valid.
REQ-024 req dropping during SETUP/STROBE/HOLD SHALL NOT abort; the access completes and the FSM then goes directly to IDLE.
REQ-025 ext_ce_n, ext_oe_n, ext_we_n SHALL come straight from flops (glitch-free).

Reset
REQ-026 While rst_n=0: state IDLE, ext_ce_n=ext_oe_n=ext_we_n=1, ext_dq_oe=0, busy=0, mem_dato=8'h00, ext_addr=0, ext_dq_o=0, counter=0, edge register=0.
REQ-027 Reset asserted mid-access SHALL deassert all strobes immediately (asynchronously); no partial write completion is guaranteed.
REQ-028 After reset release a req already high SHALL NOT start an access until it falls and rises again.

Configuration
REQ-029 Macro HUC_MEM_RD_CACHE_EN: when defined, a single-entry read cache (address tag + data + valid) SHALL be kept; a read whose address equals the valid tag SHALL skip SETUP/STROBE/HOLD, load mem_dato from the cache in the start cycle, keep busy low, and go straight to WAIT_REL; a write to the tag address SHALL update the cached data; reset clears valid. When undefined, every read performs an external access and no cache logic exists.

Verification
REQ-030 Read: WAIT_CYC=3, ext_dq_i=8'hA5, req rises at cycle 0 -> ext_oe_n low cycles 2-4, mem_dato=8'hA5 at cycle 5, busy high cycles 1-5.
REQ-031 Write: mem_addr=19'h40010, mem_dati=8'h3C -> ext_we_n low 3 cycles, ext_dq_o=8'h3C and ext_dq_oe=1 from SETUP through HOLD, ext_addr=19'h40010.
REQ-032 req held high for 20 cycles -> exactly one access; drop and re-raise -> second access.
REQ-033 oe=we=1 -> read only, ext_we_n stays 1 throughout.
REQ-034 rst_n low during STROBE of a write -> ext_we_n=1 and ext_dq_oe=0 without waiting for clk; after release, high req does not start an access.
REQ-035 With HUC_MEM_RD_CACHE_EN: two reads of 19'h00123 -> second returns same data with ext_ce_n staying 1 and busy staying 0.
